// File: rtl/dct_block_scheduler.sv
// dct_block_scheduler: shares one 2D DCT pipeline between N_REQ requesters.
// Each requester sends an 8x8 block as 8 row beats. Requesters are granted
// round-robin, one whole block at a time. Every block is tagged with its
// requester index, and at most MAX_INFLIGHT blocks may be inside the DCT.
// Completion tags are returned in issue order.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   s_tdata_i           per-requester row data, requester k in slice k
//   s_tvalid_i          per-requester valid
//   s_tlast_i           per-requester last (checked only)
//   s_tready_o          per-requester ready (combinational from m_tready_i)
//   m_tdata_o           row to the DCT
//   m_tvalid_o          valid to the DCT
//   m_tlast_o           last row of a block
//   m_tid_o             tag of the current block
//   m_tready_i          ready from the DCT
//   blk_done_i          DCT output side finished one block
//   done_vld_o          completed-tag valid pulse
//   done_tid_o          completed tag
//   credits_o           free in-flight slots
//   err_o               sticky errors: [0] tlast mismatch, [1] done underflow
module dct_block_scheduler #(
  parameter int unsigned PX_WIDTH     = 8,
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned TID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int unsigned CRD_W       = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ*PX_WIDTH*8-1:0] s_tdata_i,
  input  logic [N_REQ-1:0]            s_tvalid_i,
  input  logic [N_REQ-1:0]            s_tlast_i,
  output logic [N_REQ-1:0]            s_tready_o,
  output logic [PX_WIDTH*8-1:0]       m_tdata_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i,
  output logic                        m_tlast_o,
  output logic [TID_W-1:0]            m_tid_o,
  input  logic                        blk_done_i,
  output logic                        done_vld_o,
  output logic [TID_W-1:0]            done_tid_o,
  output logic [CRD_W-1:0]            credits_o,
  output logic [1:0]                  err_o
);

  localparam int unsigned ROW_W = PX_WIDTH * 8;
  localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [TID_W-1:0] r_grant, w_grant_nxt;
  logic [TID_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [2:0]       r_row_cnt, w_row_cnt_nxt;
  logic [1:0]       r_err, w_err_nxt;
  logic [CRD_W-1:0] r_credits;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [TID_W-1:0] r_fifo [MAX_INFLIGHT];
  logic             r_done_vld;
  logic [TID_W-1:0] r_done_tid;

  logic [ROW_W-1:0] w_sel_data;
  logic             w_sel_valid, w_sel_last;
  logic [TID_W-1:0] w_pick, w_grant_inc;
  logic             w_busy, w_push, w_pop, w_empty, w_hs, w_row_last;
  int               w_idx;

  // Lane of the currently granted requester
  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (r_grant == TID_W'(k)) begin
        w_sel_data  = s_tdata_i[k*ROW_W +: ROW_W];
        w_sel_valid = s_tvalid_i[k];
        w_sel_last  = s_tlast_i[k];
      end
    end
  end

  // Round-robin pick: walk offsets high to low so the smallest offset wins
  always_comb begin
    w_pick = r_rr_ptr;
    w_idx  = 0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= int'(N_REQ)) w_idx = w_idx - int'(N_REQ);
      for (int k = 0; k < int'(N_REQ); k++) begin
        if ((k == w_idx) && s_tvalid_i[k]) w_pick = TID_W'(k);
      end
    end
  end

  assign w_grant_inc = (r_grant == TID_W'(N_REQ - 1)) ? '0 : r_grant + TID_W'(1);
  assign w_busy      = (r_state == S_BUSY);
  assign w_row_last  = (r_row_cnt == 3'd7);
  assign w_empty     = (r_credits == CRD_W'(MAX_INFLIGHT));
  assign w_push      = (r_state == S_IDLE) && (r_credits != '0) && (|s_tvalid_i);
  assign w_pop       = blk_done_i && !w_empty;
  assign w_hs        = w_busy && w_sel_valid && m_tready_i;

  // Next-state and sticky error logic
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_row_cnt_nxt = r_row_cnt;
    w_err_nxt     = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_push) begin
          w_grant_nxt = w_pick;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_hs) begin
          if (w_sel_last != w_row_last) w_err_nxt[0] = 1'b1;
          if (w_row_last) begin
            w_row_cnt_nxt = 3'd0;
            w_rr_ptr_nxt  = w_grant_inc;
            w_state_nxt   = S_IDLE;
          end else begin
            w_row_cnt_nxt = r_row_cnt + 3'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (blk_done_i && w_empty) w_err_nxt[1] = 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_row_cnt <= 3'd0;
      r_err     <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_row_cnt <= w_row_cnt_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Credits, tag FIFO pointers and completion output
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_credits  <= CRD_W'(MAX_INFLIGHT);
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_done_vld <= 1'b0;
      r_done_tid <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_credits <= r_credits - CRD_W'(1);
        2'b01:   r_credits <= r_credits + CRD_W'(1);
        default: r_credits <= r_credits;
      endcase
      r_done_vld <= w_pop;
      if (w_pop) r_done_tid <= r_fifo[r_rd_ptr];
    end
  end

  // Tag storage; contents are only meaningful between push and pop
  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_pick;
  end

  // Data path is a pure mux while a block is granted
  always_comb begin
    s_tready_o = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (w_busy && (r_grant == TID_W'(k))) s_tready_o[k] = m_tready_i;
    end
  end

  assign m_tdata_o  = w_busy ? w_sel_data : '0;
  assign m_tvalid_o = w_busy && w_sel_valid;
  assign m_tlast_o  = w_busy && w_row_last;
  assign m_tid_o    = r_grant;
  assign done_vld_o = r_done_vld;
  assign done_tid_o = r_done_tid;
  assign credits_o  = r_credits;
  assign err_o      = r_err;

endmodule

// File: tb/tb_dct_block_scheduler.sv
module tb_dct_block_scheduler;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [191:0] s_tdata_i;
  logic [2:0]   s_tvalid_i;
  logic [2:0]   s_tlast_i;
  logic [2:0]   s_tready_o;
  logic [63:0]  m_tdata_o;
  logic         m_tvalid_o;
  logic         m_tready_i;
  logic         m_tlast_o;
  logic [1:0]   m_tid_o;
  logic         blk_done_i;
  logic         done_vld_o;
  logic [1:0]   done_tid_o;
  logic [2:0]   credits_o;
  logic [1:0]   err_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rowc [3];
  logic hs [3];
  logic [2:0] en;
  logic gap_on, nogap, bad_last;

  dct_block_scheduler #(.PX_WIDTH(8), .N_REQ(3), .MAX_INFLIGHT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_tdata_i(s_tdata_i), .s_tvalid_i(s_tvalid_i), .s_tlast_i(s_tlast_i),
    .s_tready_o(s_tready_o),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .m_tlast_o(m_tlast_o), .m_tid_o(m_tid_o),
    .blk_done_i(blk_done_i), .done_vld_o(done_vld_o), .done_tid_o(done_tid_o),
    .credits_o(credits_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pix(input int k, input int r);
    logic [63:0] p;
    for (int j = 0; j < 8; j++) p[j*8 +: 8] = 8'(k*64 + r*8 + j);
    return p;
  endfunction

  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      s_tdata_i[k*64 +: 64] = pix(k, rowc[k]);
      s_tlast_i[k]  = (rowc[k] == 7) || (bad_last && k == 1 && rowc[k] == 5);
      s_tvalid_i[k] = en[k] && (nogap || !gap_on || ($urandom_range(9) >= 3));
    end
    m_tready_i = nogap || !gap_on || ($urandom_range(9) >= 3);
  endtask

  // One clock: sources advance on their own handshakes, then re-drive
  task automatic step();
    for (int k = 0; k < 3; k++) hs[k] = s_tvalid_i[k] & s_tready_o[k];
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 3; k++) if (hs[k]) rowc[k] = (rowc[k] + 1) % 8;
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; en = 3'b000; blk_done_i = 1'b0;
    bad_last = 1'b0; gap_on = 1'b0; nogap = 1'b0;
    for (int k = 0; k < 3; k++) rowc[k] = 0;
    drive();
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
  endtask

  // Decision cycle: no data moves, credits as expected before the grant
  task automatic grant_cycle(input int exp_cred);
    nogap = 1'b1;
    drive();
    #1;
    chk("idle_vld", 64'(m_tvalid_o), 64'd0);
    chk("idle_credits", 64'(credits_o), 64'(exp_cred));
    nogap = 1'b0;
    step();
  endtask

  // Eight handshakes of one block from requester tid
  task automatic block_beats(input int tid);
    int row = 0;
    int guard = 0;
    logic [2:0] er;
    while (row < 8 && guard < 200) begin
      er = 3'b000;
      if (m_tready_i) er[tid] = 1'b1;
      chk("blk_tid", 64'(m_tid_o), 64'(tid));
      chk("blk_ready", 64'(s_tready_o), 64'(er));
      chk("blk_vld", 64'(m_tvalid_o), 64'(s_tvalid_i[tid]));
      if (s_tvalid_i[tid]) begin
        chk("blk_data", m_tdata_o, pix(tid, row));
        chk("blk_last", 64'(m_tlast_o), 64'(row == 7));
      end
      if (s_tvalid_i[tid] && m_tready_i) row++;
      step();
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      n_fail++;
      $error("FAIL blk_timeout observed_rows=%0d expected_rows=8", row);
    end
  endtask

  initial begin
    // Reset values
    rst_i = 1'b0; en = 3'b000; blk_done_i = 1'b0;
    bad_last = 1'b0; gap_on = 1'b0; nogap = 1'b0;
    for (int k = 0; k < 3; k++) rowc[k] = 0;
    en = 3'b111;
    drive();
    @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(s_tready_o), 64'd0);
    chk("rst_vld", 64'(m_tvalid_o), 64'd0);
    chk("rst_credits", 64'(credits_o), 64'd4);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_done_vld", 64'(done_vld_o), 64'd0);
    chk("rst_done_tid", 64'(done_tid_o), 64'd0);
    do_reset();

    // Single requester, back-to-back blocks
    en = 3'b001;
    grant_cycle(4);
    block_beats(0);
    grant_cycle(3);
    chk("t1_credits2", 64'(credits_o), 64'd2);
    block_beats(0);

    // Round robin until credits run out, then one completion
    do_reset();
    en = 3'b111;
    grant_cycle(4); block_beats(0);
    grant_cycle(3); block_beats(1);
    grant_cycle(2); block_beats(2);
    grant_cycle(1); block_beats(0);
    repeat (3) begin
      chk("t2_stall_vld", 64'(m_tvalid_o), 64'd0);
      chk("t2_stall_credits", 64'(credits_o), 64'd0);
      chk("t2_stall_ready", 64'(s_tready_o), 64'd0);
      step();
    end
    blk_done_i = 1'b1;
    step();
    blk_done_i = 1'b0;
    #1;
    chk("t2_done_vld", 64'(done_vld_o), 64'd1);
    chk("t2_done_tid", 64'(done_tid_o), 64'd0);
    chk("t2_credits1", 64'(credits_o), 64'd1);
    chk("t2_idle_vld", 64'(m_tvalid_o), 64'd0);
    step();
    chk("t2_done_clr", 64'(done_vld_o), 64'd0);
    chk("t2_credits0", 64'(credits_o), 64'd0);
    chk("t2_next_tid", 64'(m_tid_o), 64'd1);
    block_beats(1);

    // Random stalls on both sides of the mux
    do_reset();
    en = 3'b111;
    gap_on = 1'b1;
    grant_cycle(4); block_beats(0);
    grant_cycle(3); block_beats(1);
    grant_cycle(2); block_beats(2);
    gap_on = 1'b0;

    // Early tlast from requester 1
    do_reset();
    en = 3'b010;
    bad_last = 1'b1;
    chk("t4_err_pre", 64'(err_o), 64'd0);
    grant_cycle(4);
    block_beats(1);
    chk("t4_err", 64'(err_o), 64'd1);
    step();
    step();
    chk("t4_err_sticky", 64'(err_o), 64'd1);

    // Completion with nothing in flight
    do_reset();
    blk_done_i = 1'b1;
    step();
    blk_done_i = 1'b0;
    #1;
    chk("t5_err", 64'(err_o), 64'd2);
    chk("t5_done_vld", 64'(done_vld_o), 64'd0);
    chk("t5_credits", 64'(credits_o), 64'd4);
    step();
    chk("t5_done_vld2", 64'(done_vld_o), 64'd0);

    // Reset in the middle of a block
    do_reset();
    en = 3'b010;
    grant_cycle(4);
    block_beats(1);
    en = 3'b110;
    grant_cycle(3);
    for (int b = 0; b < 3; b++) begin
      chk("t6_tid", 64'(m_tid_o), 64'd2);
      step();
    end
    chk("t6_beat4_vld", 64'(m_tvalid_o), 64'd1);
    rst_i = 1'b0;
    #1;
    chk("t6_rst_vld", 64'(m_tvalid_o), 64'd0);
    chk("t6_rst_ready", 64'(s_tready_o), 64'd0);
    chk("t6_rst_credits", 64'(credits_o), 64'd4);
    chk("t6_rst_tlast", 64'(m_tlast_o), 64'd0);
    do_reset();
    en = 3'b111;
    grant_cycle(4);
    block_beats(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dct_block_scheduler.md
Name: dct_block_scheduler

Overview:
- Shares one 2D DCT pipeline between N_REQ requesters (e.g. Y, Cb, Cr line-buffer outputs).
- Each requester presents 8x8 blocks as 8 beats, one parallel 8-pixel row per beat.
- Arbitrates round-robin at block granularity, tags every block with the requester index, and limits blocks in flight inside the DCT to MAX_INFLIGHT.
- Returns the tag of each completed block in issue order.
- Sits between the per-component line adapters and the DCT input.

Parameters:
- PX_WIDTH, 8, bits per pixel.
- N_REQ, 3, number of requesters (2..8).
- MAX_INFLIGHT, 4, maximum blocks issued but not yet completed (1..16).
- TID_W, $clog2(N_REQ) with a minimum of 1, width of the tag (derived, localparam).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- s_tdata_i  in  N_REQ*PX_WIDTH*8  row data; requester k occupies slice k
- s_tvalid_i  in  N_REQ  per-requester valid
- s_tlast_i  in  N_REQ  per-requester last; asserted on row 7 of a block
- s_tready_o  out  N_REQ  per-requester ready
- m_tdata_o  out  PX_WIDTH*8  row to DCT
- m_tvalid_o  out  1  valid to DCT
- m_tready_i  in  1  ready from DCT
- m_tlast_o  out  1  row 7 of a block
- m_tid_o  out  TID_W  requester index of the current block
- blk_done_i  in  1  1-cycle pulse from DCT output side: one block fully emitted
- done_vld_o  out  1  1-cycle pulse: tag of a completed block is valid
- done_tid_o  out  TID_W  tag of the completed block
- credits_o  out  $clog2(MAX_INFLIGHT+1)  free in-flight slots
- err_o  out  2  sticky errors; [0] tlast mismatch, [1] blk_done underflow

Behaviour:
- Reset (asynchronous, rst_i=0):
  - state=IDLE, rr_ptr=0, row_cnt=0, grant=0, credits=MAX_INFLIGHT.
  - Tag FIFO empty; err_o=0; done_vld_o=0; done_tid_o=0.
  - All s_tready_o=0; m_tvalid_o=0.
  - Reset mid-block discards the partial block; no recovery of in-flight tags.
- State IDLE:
  - If credits>0 and any s_tvalid_i is set, pick the first valid index searching from rr_ptr upward, with wrap.
  - Register that index as grant, push it into the tag FIFO, decrement credits, go to BUSY.
  - This is one decision cycle: no data moves in IDLE.
  - If credits==0, stay in IDLE even when requests are pending.
- State BUSY:
  - Combinational mux from the granted requester:
    - m_tvalid_o = s_tvalid_i[grant]
    - m_tdata_o = slice[grant]
    - s_tready_o[grant] = m_tready_i
    - all other readies are 0
  - m_tid_o = grant (held stable through BUSY).
  - m_tlast_o = (row_cnt==7), generated internally; the input tlast is only checked.
  - On each handshake (m_tvalid_o & m_tready_i):
    - If s_tlast_i[grant] != (row_cnt==7), set err_o[0]; streaming continues.
    - If row_cnt==7: row_cnt=0, rr_ptr=(grant+1) mod N_REQ, go to IDLE.
    - Otherwise row_cnt increments.
  - The grant is locked for exactly 8 handshakes. Deasserting tvalid stalls the block; it is never preempted.
- Minimum block period: 9 cycles (1 decision cycle + 8 beats).
- blk_done_i:
  - If the tag FIFO is non-empty: pop it, and the next cycle drive done_vld_o=1 with done_tid_o = popped tag; credits increment.
  - If the tag FIFO is empty: ignore the pulse, set err_o[1], credits unchanged.
  - Simultaneous push (grant) and pop (blk_done_i) in the same cycle: both happen, credits net unchanged, FIFO occupancy unchanged.
  - A pop in the grant cycle when the FIFO held 0 entries is an underflow, even though a push occurs that same cycle.
- Tag FIFO:
  - Depth MAX_INFLIGHT, circular read/write pointers with wrap.
  - Cannot overflow, because a push requires credits>0.
- Invariant: credits + FIFO occupancy == MAX_INFLIGHT at all times.

Test Plan:
- Single requester 0, continuous valid, m_tready_i=1, N_REQ=3:
  - 8 beats with m_tid_o=0 and m_tlast_o on beat 8.
  - Next block starts 1 idle cycle later.
  - credits_o goes 4→3→2.
- All three requesters valid, no blk_done_i, MAX_INFLIGHT=4:
  - Blocks issued with tags 0,1,2,0, then m_tvalid_o stays 0 and credits_o=0.
  - One blk_done_i pulse → done_vld_o next cycle with done_tid_o=0, credits_o=1, then block tag 1 is issued.
- Random m_tready_i and s_tvalid_i gaps within a block (30% stall rate):
  - Data of the granted requester is forwarded bit-exact in order.
  - Other requesters see s_tready_o=0 for the whole block.
- Requester 1 asserts s_tlast_i on row 5 → err_o=2'b01 and stays set. The block still completes on the 8th handshake.
- blk_done_i while the FIFO is empty → err_o[1]=1, done_vld_o stays 0, credits_o=4.
- Assert reset during beat 4 of a block → all outputs return to reset values immediately. After release, arbitration restarts from requester 0 with credits_o=4.
